vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_axis_cnt.sv | 56 +++++
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the raster timing generator.
//   vga_timing_t  packed timing set (h_active,h_fp,h_sync,h_bp,v_active,v_fp,v_sync,v_bp)
//   VGA_DEF_*     640x480@60 reset timing
//   h_total/v_total  line/frame totals, two bits wider than a field so a
//                    sum of four fields can never wrap
package vga_pkg;

  localparam int VGA_H_W = 12;
  localparam int VGA_V_W = 11;

  localparam int VGA_DEF_H_ACTIVE = 640;
  localparam int VGA_DEF_H_FP     = 16;
  localparam int VGA_DEF_H_SYNC   = 96;
  localparam int VGA_DEF_H_BP     = 48;
  localparam int VGA_DEF_V_ACTIVE = 480;
  localparam int VGA_DEF_V_FP     = 10;
  localparam int VGA_DEF_V_SYNC   = 2;
  localparam int VGA_DEF_V_BP     = 33;

  typedef struct packed {
    logic [VGA_H_W-1:0] h_active;
    logic [VGA_H_W-1:0] h_fp;
    logic [VGA_H_W-1:0] h_sync;
    logic [VGA_H_W-1:0] h_bp;
    logic [VGA_V_W-1:0] v_active;
    logic [VGA_V_W-1:0] v_fp;
    logic [VGA_V_W-1:0] v_sync;
    logic [VGA_V_W-1:0] v_bp;
  } vga_timing_t;

  function automatic logic [VGA_H_W+1:0] h_total(input logic [VGA_H_W-1:0] a,
                                                 input logic [VGA_H_W-1:0] fp,
                                                 input logic [VGA_H_W-1:0] s,
                                                 input logic [VGA_H_W-1:0] bp);
    return {2'b00, a} + {2'b00, fp} + {2'b00, s} + {2'b00, bp};
  endfunction

  function automatic logic [VGA_V_W+1:0] v_total(input logic [VGA_V_W-1:0] a,
                                                 input logic [VGA_V_W-1:0] fp,
                                                 input logic [VGA_V_W-1:0] s,
                                                 input logic [VGA_V_W-1:0] bp);
    return {2'b00, a} + {2'b00, fp} + {2'b00, s} + {2'b00, bp};
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one raster axis (used for both horizontal and vertical).
// Holds the position counter and decodes the position it is about to move to,
// so the parent can register outputs that describe the new position.
//   clk, rst_n      clock, async active-low reset (counter -> RST_CNT)
//   step            advance one position this clock
//   len_*           active / front porch / sync / back porch lengths
//   pos             position after this clock (equals current when !step)
//   last            current position is the final one of the axis
//   pos_act         pos lies in the active region
//   pos_sync        pos lies in the sync region
module vga_axis_cnt #(
  parameter int W       = 12,
  parameter int RST_CNT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic [W-1:0] len_active,
  input  logic [W-1:0] len_fp,
  input  logic [W-1:0] len_sync,
  input  logic [W-1:0] len_bp,
  output logic [W-1:0] pos,
  output logic         last,
  output logic         pos_act,
  output logic         pos_sync
);

  logic [W-1:0] cnt;
  logic [W:0]   total;
  logic [W:0]   sync_beg;
  logic [W:0]   sync_end;

  // Region boundaries are summed one bit wider; accepted timing sets keep the
  // total at or below 2^W, so these never wrap.
  always_comb begin
    total    = {1'b0, len_active} + {1'b0, len_fp} + {1'b0, len_sync} + {1'b0, len_bp};
    sync_beg = {1'b0, len_active} + {1'b0, len_fp};
    sync_end = sync_beg + {1'b0, len_sync};
    last     = ({1'b0, cnt} == total - (W+1)'(1));
    pos      = cnt;
    if (step) begin
      pos = last ? '0 : cnt + W'(1);
    end
    pos_act  = ({1'b0, pos} < {1'b0, len_active});
    pos_sync = ({1'b0, pos} >= sync_beg) && ({1'b0, pos} < sync_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(RST_CNT);
    end else begin
      cnt <= pos;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-reconfigurable VGA/DVI raster timing generator.
//   clk, rst_n        clock, async active-low reset
//   pix_stb           pixel enable; the raster advances only when high
//   cfg_valid/ready   handshake offering a new timing set (cfg_timing)
//   cfg_err           one-clock pulse: offered set rejected
//   hsync, vsync      syncs, active level HS_POL / VS_POL
//   de, x, y          active video and its column/row (0 outside active)
//   line_start, frame_start, animate  one-clock event pulses
// An accepted set waits in a shadow slot and becomes live on the pix_stb that
// wraps the last pixel of the frame, so a mode switch never tears a frame.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_W          = VGA_H_W,
  parameter int   V_W          = VGA_V_W,
  parameter int   DEF_H_ACTIVE = VGA_DEF_H_ACTIVE,
  parameter int   DEF_H_FP     = VGA_DEF_H_FP,
  parameter int   DEF_H_SYNC   = VGA_DEF_H_SYNC,
  parameter int   DEF_H_BP     = VGA_DEF_H_BP,
  parameter int   DEF_V_ACTIVE = VGA_DEF_V_ACTIVE,
  parameter int   DEF_V_FP     = VGA_DEF_V_FP,
  parameter int   DEF_V_SYNC   = VGA_DEF_V_SYNC,
  parameter int   DEF_V_BP     = VGA_DEF_V_BP,
  parameter logic HS_POL       = 1'b0,
  parameter logic VS_POL       = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_stb,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  vga_timing_t   cfg_timing,
  output logic          cfg_err,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          animate
);

  localparam vga_timing_t DEF_TIMING = '{
    h_active: VGA_H_W'(DEF_H_ACTIVE), h_fp: VGA_H_W'(DEF_H_FP),
    h_sync:   VGA_H_W'(DEF_H_SYNC),   h_bp: VGA_H_W'(DEF_H_BP),
    v_active: VGA_V_W'(DEF_V_ACTIVE), v_fp: VGA_V_W'(DEF_V_FP),
    v_sync:   VGA_V_W'(DEF_V_SYNC),   v_bp: VGA_V_W'(DEF_V_BP)
  };

  // Reset parks the raster on the final pixel so the first strobe enters (0,0).
  localparam int H_RST = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP - 1;
  localparam int V_RST = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP - 1;

  vga_timing_t live_q;
  vga_timing_t shadow_q;
  logic        shadow_full_q;

  logic [H_W-1:0] h_pos;
  logic           h_last, h_act, h_sync_on;
  logic [V_W-1:0] v_pos;
  logic           v_last, v_act, v_sync_on;
  logic           v_step;
  logic           frame_wrap;

  logic [VGA_H_W+1:0] cfg_h_sum;
  logic [VGA_V_W+1:0] cfg_v_sum;
  logic               cfg_bad;

  assign v_step     = pix_stb & h_last;
  assign frame_wrap = v_step & v_last;
  assign cfg_ready  = ~shadow_full_q;

  vga_axis_cnt #(.W(H_W), .RST_CNT(H_RST)) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (pix_stb),
    .len_active (H_W'(live_q.h_active)),
    .len_fp     (H_W'(live_q.h_fp)),
    .len_sync   (H_W'(live_q.h_sync)),
    .len_bp     (H_W'(live_q.h_bp)),
    .pos        (h_pos),
    .last       (h_last),
    .pos_act    (h_act),
    .pos_sync   (h_sync_on)
  );

  vga_axis_cnt #(.W(V_W), .RST_CNT(V_RST)) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (v_step),
    .len_active (V_W'(live_q.v_active)),
    .len_fp     (V_W'(live_q.v_fp)),
    .len_sync   (V_W'(live_q.v_sync)),
    .len_bp     (V_W'(live_q.v_bp)),
    .pos        (v_pos),
    .last       (v_last),
    .pos_act    (v_act),
    .pos_sync   (v_sync_on)
  );

  // A set is unusable if it has an empty active or sync region, or if a
  // total would not fit the counter (total-1 must be representable).
  always_comb begin
    cfg_h_sum = h_total(cfg_timing.h_active, cfg_timing.h_fp, cfg_timing.h_sync, cfg_timing.h_bp);
    cfg_v_sum = v_total(cfg_timing.v_active, cfg_timing.v_fp, cfg_timing.v_sync, cfg_timing.v_bp);
    cfg_bad   = (cfg_timing.h_active == '0) || (cfg_timing.h_sync == '0) ||
                (cfg_timing.v_active == '0) || (cfg_timing.v_sync == '0) ||
                (int'(cfg_h_sum) > (1 << H_W)) || (int'(cfg_v_sum) > (1 << V_W));
  end

  // Shadow handshake and live timing. Promotion only happens while the slot
  // is full, acceptance only while it is empty, so an offer landing on the
  // wrap edge is shadowed now and promoted at the following wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q        <= DEF_TIMING;
      shadow_q      <= DEF_TIMING;
      shadow_full_q <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (frame_wrap && shadow_full_q) begin
        live_q        <= shadow_q;
        shadow_full_q <= 1'b0;
      end
      if (cfg_valid && !shadow_full_q) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          shadow_q      <= cfg_timing;
          shadow_full_q <= 1'b1;
        end
      end
    end
  end

  // Raster outputs describe the position being entered. Decoding with the
  // pre-wrap live set is safe on a mode switch: position (0,0) is active and
  // outside sync under any accepted set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      animate     <= 1'b0;
    end else begin
      line_start  <= v_step;
      frame_start <= frame_wrap;
      animate     <= v_step && (v_pos == V_W'(live_q.v_active));
      if (pix_stb) begin
        de    <= h_act & v_act;
        x     <= (h_act & v_act) ? h_pos : '0;
        y     <= (h_act & v_act) ? v_pos : '0;
        hsync <= h_sync_on ? HS_POL : ~HS_POL;
        vsync <= v_sync_on ? VS_POL : ~VS_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. The vertical reset
// timing is shortened to 4/1/1/2 lines (V_TOTAL 8) so whole frames stay
// short; the horizontal reset timing is the real 640/16/96/48.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_stb;
  logic        cfg_valid;
  logic        cfg_ready;
  vga_timing_t cfg_timing;
  logic        cfg_err;
  logic        hsync, vsync, de;
  logic [11:0] x;
  logic [10:0] y;
  logic        line_start, frame_start, animate;

  int compared   = 0;
  int mismatched = 0;
  int stb_div    = 1;
  int div_cnt    = 0;

  int frame_len, line_len, line_cnt, hs_start, hs_len, vs_start, vs_len;
  int de_cnt, anim_k, anim_cnt, x_max, y_max, err_cnt, ready_after;

  vga_timing_t t_small;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .DEF_V_ACTIVE (4),
    .DEF_V_FP     (1),
    .DEF_V_SYNC   (1),
    .DEF_V_BP     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_stb     (pix_stb),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_timing  (cfg_timing),
    .cfg_err     (cfg_err),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .animate     (animate)
  );

  function automatic vga_timing_t mkTiming(input int ha, input int hf, input int hs, input int hb,
                                           input int va, input int vf, input int vs, input int vb);
    vga_timing_t t;
    t.h_active = VGA_H_W'(ha);
    t.h_fp     = VGA_H_W'(hf);
    t.h_sync   = VGA_H_W'(hs);
    t.h_bp     = VGA_H_W'(hb);
    t.v_active = VGA_V_W'(va);
    t.v_fp     = VGA_V_W'(vf);
    t.v_sync   = VGA_V_W'(vs);
    t.v_bp     = VGA_V_W'(vb);
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with pix_stb from the divider; outputs are sampled 1ns later.
  task automatic applyStimulus();
    pix_stb = (div_cnt == 0);
    @(posedge clk);
    #1;
    div_cnt = (div_cnt + 1 >= stb_div) ? 0 : div_cnt + 1;
  endtask

  task automatic idleClock();
    pix_stb = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_hsync"},       32'(hsync),       32'd1);
    checkOutput({pfx, "_vsync"},       32'(vsync),       32'd1);
    checkOutput({pfx, "_de"},          32'(de),          32'd0);
    checkOutput({pfx, "_x"},           32'(x),           32'd0);
    checkOutput({pfx, "_y"},           32'(y),           32'd0);
    checkOutput({pfx, "_line_start"},  32'(line_start),  32'd0);
    checkOutput({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
    checkOutput({pfx, "_animate"},     32'(animate),     32'd0);
    checkOutput({pfx, "_cfg_ready"},   32'(cfg_ready),   32'd1);
    checkOutput({pfx, "_cfg_err"},     32'(cfg_err),     32'd0);
  endtask

  // Runs from just after a frame_start until the next one (or the bound),
  // collecting clock-domain statistics. k counts clocks from the last
  // frame_start; an offer is presented during the edge numbered offer_k.
  task automatic runFrame(input int offer_k, input vga_timing_t offer_t, input int bound);
    frame_len = 0; line_len = 0; line_cnt = 0; hs_start = -1; hs_len = 0;
    vs_start = -1; vs_len = 0; de_cnt = 0; anim_k = -1; anim_cnt = 0;
    x_max = 0; y_max = 0; err_cnt = 0; ready_after = -1;
    for (int k = 1; k <= bound; k++) begin
      if (k == offer_k) begin
        cfg_valid  = 1'b1;
        cfg_timing = offer_t;
      end
      applyStimulus();
      if (k == offer_k) begin
        cfg_valid   = 1'b0;
        ready_after = int'(cfg_ready);
      end
      if (cfg_err) err_cnt++;
      if (line_start) begin
        line_cnt++;
        if (line_len == 0) line_len = k;
      end
      if (!hsync && line_len == 0) begin
        if (hs_start < 0) hs_start = k;
        hs_len++;
      end
      if (!vsync) begin
        if (vs_start < 0) vs_start = k;
        vs_len++;
      end
      if (de) de_cnt++;
      if (int'(x) > x_max) x_max = int'(x);
      if (int'(y) > y_max) y_max = int'(y);
      if (animate) begin
        anim_cnt++;
        if (anim_k < 0) anim_k = k;
      end
      if (frame_start) begin
        frame_len = k;
        break;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pix_stb    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_timing = mkTiming(640, 16, 96, 48, 480, 10, 2, 33);
    t_small    = mkTiming(16, 2, 4, 2, 3, 1, 1, 1);

    // Reset values, then hold while pix_stb stays low
    repeat (3) idleClock();
    checkReset("rst");
    rst_n = 1'b1;
    repeat (3) idleClock();
    checkReset("idle");

    // First strobe enters (0,0)
    stb_div = 1;
    div_cnt = 0;
    applyStimulus();
    checkOutput("first_frame_start", 32'(frame_start), 32'd1);
    checkOutput("first_line_start",  32'(line_start),  32'd1);
    checkOutput("first_de",          32'(de),          32'd1);
    checkOutput("first_x",           32'(x),           32'd0);
    checkOutput("first_y",           32'(y),           32'd0);
    checkOutput("first_hsync",       32'(hsync),       32'd1);

    // Default frame, pix_stb every clock: 800 x 8
    runFrame(-1, t_small, 10000);
    checkOutput("def_frame_len", 32'(frame_len), 32'd6400);
    checkOutput("def_line_len",  32'(line_len),  32'd800);
    checkOutput("def_line_cnt",  32'(line_cnt),  32'd8);
    checkOutput("def_hs_start",  32'(hs_start),  32'd656);
    checkOutput("def_hs_len",    32'(hs_len),    32'd96);
    checkOutput("def_vs_start",  32'(vs_start),  32'd4000);
    checkOutput("def_vs_len",    32'(vs_len),    32'd800);
    checkOutput("def_de_cnt",    32'(de_cnt),    32'd2560);
    checkOutput("def_anim_k",    32'(anim_k),    32'd3200);
    checkOutput("def_anim_cnt",  32'(anim_cnt),  32'd1);
    checkOutput("def_x_max",     32'(x_max),     32'd639);
    checkOutput("def_y_max",     32'(y_max),     32'd3);

    // Horizontal total 4160 does not fit 12 bits: rejected
    cfg_valid  = 1'b1;
    cfg_timing = mkTiming(4000, 16, 96, 48, 480, 10, 2, 33);
    applyStimulus();
    cfg_valid = 1'b0;
    checkOutput("ovf_cfg_err",   32'(cfg_err),   32'd1);
    checkOutput("ovf_cfg_ready", 32'(cfg_ready), 32'd1);
    applyStimulus();
    checkOutput("ovf_err_clear", 32'(cfg_err),   32'd0);

    // h_sync = 0 rejected mid-frame; timing unchanged (frame began 2 clocks ago)
    runFrame(100, mkTiming(640, 16, 0, 48, 480, 10, 2, 33), 10000);
    checkOutput("rej_err_cnt",     32'(err_cnt),     32'd1);
    checkOutput("rej_ready_after", 32'(ready_after), 32'd1);
    checkOutput("rej_frame_len",   32'(frame_len),   32'd6398);

    // Offer on the wrap edge: shadowed now, live one frame later
    runFrame(6400, t_small, 10000);
    checkOutput("wrap_frame_len",   32'(frame_len),   32'd6400);
    checkOutput("wrap_ready_after", 32'(ready_after), 32'd0);
    runFrame(-1, t_small, 10000);
    checkOutput("wrap_next_len",    32'(frame_len),   32'd6400);
    checkOutput("wrap_ready_back",  32'(cfg_ready),   32'd1);
    runFrame(-1, t_small, 10000);
    checkOutput("small_frame_len",  32'(frame_len),   32'd144);
    checkOutput("small_line_len",   32'(line_len),    32'd24);
    checkOutput("small_hs_start",   32'(hs_start),    32'd18);
    checkOutput("small_hs_len",     32'(hs_len),      32'd4);
    checkOutput("small_vs_start",   32'(vs_start),    32'd96);
    checkOutput("small_vs_len",     32'(vs_len),      32'd24);
    checkOutput("small_de_cnt",     32'(de_cnt),      32'd48);
    checkOutput("small_anim_k",     32'(anim_k),      32'd72);

    // pix_stb every 4th clock on the small timing
    stb_div = 4;
    div_cnt = 0;
    runFrame(-1, t_small, 2000);
    checkOutput("div4_sync_len",   32'(frame_len), 32'd573);
    runFrame(-1, t_small, 2000);
    checkOutput("div4_frame_len",  32'(frame_len), 32'd576);
    checkOutput("div4_line_len",   32'(line_len),  32'd96);
    checkOutput("div4_line_cnt",   32'(line_cnt),  32'd6);
    checkOutput("div4_hs_start",   32'(hs_start),  32'd72);
    checkOutput("div4_hs_len",     32'(hs_len),    32'd16);
    checkOutput("div4_vs_start",   32'(vs_start),  32'd384);
    checkOutput("div4_vs_len",     32'(vs_len),    32'd96);
    checkOutput("div4_de_cnt",     32'(de_cnt),    32'd192);
    checkOutput("div4_anim_k",     32'(anim_k),    32'd288);
    checkOutput("div4_anim_cnt",   32'(anim_cnt),  32'd1);
    applyStimulus();
    checkOutput("div4_fs_width",   32'(frame_start), 32'd0);
    checkOutput("div4_ls_width",   32'(line_start),  32'd0);

    // Reset mid-line with a pending shadow set
    stb_div    = 1;
    div_cnt    = 0;
    cfg_valid  = 1'b1;
    cfg_timing = mkTiming(32, 4, 8, 4, 4, 1, 1, 1);
    applyStimulus();
    cfg_valid = 1'b0;
    checkOutput("pend_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (5) applyStimulus();
    #2 rst_n = 1'b0;
    #1;
    checkReset("midrst");
    repeat (2) idleClock();
    rst_n   = 1'b1;
    div_cnt = 0;
    applyStimulus();
    checkOutput("rst2_frame_start", 32'(frame_start), 32'd1);
    checkOutput("rst2_de",          32'(de),          32'd1);
    runFrame(-1, t_small, 10000);
    checkOutput("rst2_frame_len",   32'(frame_len),   32'd6400);
    checkOutput("rst2_line_len",    32'(line_len),    32'd800);
    checkOutput("rst2_cfg_ready",   32'(cfg_ready),   32'd1);

    // 800x600 offered mid-frame: this frame stays 800 wide, next is 1056 wide
    runFrame(100, mkTiming(800, 40, 128, 88, 600, 1, 4, 23), 10000);
    checkOutput("svga_ready_after", 32'(ready_after), 32'd0);
    checkOutput("svga_old_len",     32'(frame_len),   32'd6400);
    checkOutput("svga_ready_back",  32'(cfg_ready),   32'd1);
    runFrame(-1, t_small, 1100);
    checkOutput("svga_line_len",    32'(line_len),    32'd1056);
    checkOutput("svga_hs_start",    32'(hs_start),    32'd840);
    checkOutput("svga_hs_len",      32'(hs_len),      32'd128);
    checkOutput("svga_x_max",       32'(x_max),       32'd799);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
